// File: rtl/ce_prescaler.sv
// Purpose : programmable clock-enable generator; one-cycle CE pulse every DIV+1 CLK cycles.
// Latency : CE rises the cycle after the edge that samples terminal count; all outputs registered.
// Backpres: ENABLE=0 freezes the counter and forces CE=0; CALIB=1 slips the phase by one cycle.
//
// Ports:
//   CLK     - rising-edge clock
//   RESETN  - asynchronous active-low reset, clears all state immediately
//   ENABLE  - run/hold; low freezes the counter and holds CE at 0
//   DIV     - new divide value (period = DIV+1), captured on LOAD
//   LOAD    - single-cycle strobe capturing DIV into the shadow register
//   CALIB   - phase slip; each high cycle delays the next CE by one cycle
//   CE      - registered enable pulse for DFFCE CE pins
//   PHASE   - current counter value (registered)
//   PENDING - high while a loaded DIV has not yet taken effect
module ce_prescaler #(
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 3
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             ENABLE,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LOAD,
  input  logic             CALIB,
  output logic             CE,
  output logic [DIV_W-1:0] PHASE,
  output logic             PENDING
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_shadow_q, div_shadow_d;
  logic             pending_q, pending_d;
  logic             ce_q, ce_d;
  logic             tc;

  // cnt never exceeds div_act: it wraps to 0 on equality, so no overflow path.
  assign tc = (cnt_q == div_act_q);

  always_comb begin
    cnt_d        = cnt_q;
    div_act_d    = div_act_q;
    div_shadow_d = div_shadow_q;
    pending_d    = pending_q;
    ce_d         = 1'b0;

    if (ENABLE && !CALIB) begin
      if (tc) begin
        cnt_d = '0;
        ce_d  = 1'b1;
        // Swap only at a period boundary so the period in progress is never altered.
        if (pending_q) begin
          div_act_d = div_shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // LOAD is captured regardless of ENABLE/CALIB. A LOAD on the same edge as a
    // swap overrides the pending clear, so the new value applies one period later
    // while the swap above still uses the old shadow contents.
    if (LOAD) begin
      div_shadow_d = DIV;
      pending_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q        <= '0;
      div_act_q    <= DIV_RST;
      div_shadow_q <= DIV_RST;
      pending_q    <= 1'b0;
      ce_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_act_q    <= div_act_d;
      div_shadow_q <= div_shadow_d;
      pending_q    <= pending_d;
      ce_q         <= ce_d;
    end
  end

  assign CE      = ce_q;
  assign PHASE   = cnt_q;
  assign PENDING = pending_q;

endmodule

// File: tb/tb_ce_prescaler.sv
module tb_ce_prescaler;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       ENABLE;
  logic [7:0] DIV;
  logic       LOAD;
  logic       CALIB;
  logic       CE;
  logic [7:0] PHASE;
  logic       PENDING;

  int tests = 0;
  int fails = 0;

  ce_prescaler #(.DIV_W(8), .DIV_INIT(3)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .ENABLE (ENABLE),
    .DIV    (DIV),
    .LOAD   (LOAD),
    .CALIB  (CALIB),
    .CE     (CE),
    .PHASE  (PHASE),
    .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] div;
    logic       calib;
    logic       ce;
    logic [7:0] ph;
    logic       pend;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic en, logic load, logic [7:0] div, logic calib,
                              logic ce, logic [7:0] ph, logic pend);
    vec_t v;
    v.en = en; v.load = load; v.div = div; v.calib = calib;
    v.ce = ce; v.ph = ph; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int cyc;
    int maxph;
    bit seen;

    // Rows: en, load, div, calib -> expected CE, PHASE, PENDING after the edge.
    // Free run at DIV_INIT=3
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 0,2,0));
    vq.push_back(mk(1,0,0,0, 0,3,0));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 0,2,0));
    vq.push_back(mk(1,0,0,0, 0,3,0));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 0,1,0));
    // LOAD DIV=1 at PHASE=1: current period unchanged, then period 2
    vq.push_back(mk(1,1,1,0, 0,2,1));
    vq.push_back(mk(1,0,0,0, 0,3,1));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    // Restore DIV=3
    vq.push_back(mk(1,1,3,0, 0,1,1));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 0,2,0));
    vq.push_back(mk(1,0,0,0, 0,3,0));
    // LOAD DIV=0 coincident with tc: one more 4-cycle period, then CE every cycle
    vq.push_back(mk(1,1,0,0, 1,0,1));
    vq.push_back(mk(1,0,0,0, 0,1,1));
    vq.push_back(mk(1,0,0,0, 0,2,1));
    vq.push_back(mk(1,0,0,0, 0,3,1));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    // Back to DIV=3 from DIV=0
    vq.push_back(mk(1,1,3,0, 1,0,1));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 0,2,0));
    vq.push_back(mk(1,0,0,0, 0,3,0));
    // CALIB two cycles at PHASE=3: CE delayed by 2, spacing stays 4
    vq.push_back(mk(1,0,0,1, 0,3,0));
    vq.push_back(mk(1,0,0,1, 0,3,0));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 0,2,0));
    vq.push_back(mk(1,0,0,0, 0,3,0));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    // ENABLE low 5 cycles at PHASE=2, LOAD DIV=5 captured while disabled
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 0,2,0));
    vq.push_back(mk(0,0,0,0, 0,2,0));
    vq.push_back(mk(0,0,0,0, 0,2,0));
    vq.push_back(mk(0,1,5,0, 0,2,1));
    vq.push_back(mk(0,0,0,0, 0,2,1));
    vq.push_back(mk(0,0,0,0, 0,2,1));
    vq.push_back(mk(1,0,0,0, 0,3,1));
    vq.push_back(mk(1,0,0,0, 1,0,0));
    // Period 6, then a pending LOAD DIV=2 ahead of PHASE=5
    vq.push_back(mk(1,0,0,0, 0,1,0));
    vq.push_back(mk(1,0,0,0, 0,2,0));
    vq.push_back(mk(1,0,0,0, 0,3,0));
    vq.push_back(mk(1,1,2,0, 0,4,1));
    vq.push_back(mk(1,0,0,0, 0,5,1));

    RESETN = 1'b0; ENABLE = 1'b1; DIV = 8'd0; LOAD = 1'b0; CALIB = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ce", CE, 0);
    chk("rst_phase", PHASE, 0);
    chk("rst_pending", PENDING, 0);

    @(negedge CLK);
    RESETN = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      ENABLE = vq[i].en; LOAD = vq[i].load; DIV = vq[i].div; CALIB = vq[i].calib;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_ce", i), CE, vq[i].ce);
      chk($sformatf("v%0d_phase", i), PHASE, vq[i].ph);
      chk($sformatf("v%0d_pending", i), PENDING, vq[i].pend);
      @(negedge CLK);
    end

    // Asynchronous reset mid-cycle with PENDING=1, PHASE=5
    ENABLE = 1'b1; LOAD = 1'b0; CALIB = 1'b0;
    #2 RESETN = 1'b0;
    #1;
    chk("async_ce", CE, 0);
    chk("async_phase", PHASE, 0);
    chk("async_pending", PENDING, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    // DIV_INIT restored and the pending DIV=2 discarded: CE on the 4th edge
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("post_rst%0d_ce", k), CE, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("post_rst%0d_phase", k), PHASE, k % 4);
      chk($sformatf("post_rst%0d_pending", k), PENDING, 0);
    end

    // Maximum DIV: period 2**DIV_W with PHASE reaching 255
    @(negedge CLK);
    LOAD = 1'b1; DIV = 8'd255;
    @(negedge CLK);
    LOAD = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge CLK);
      #1;
      if (CE) seen = 1;
    end
    chk("max_swap_ce_seen", seen, 1);
    chk("max_swap_pending", PENDING, 0);
    cyc = 0; maxph = 0; seen = 0;
    while (cyc < 400 && !seen) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (PHASE > maxph) maxph = PHASE;
      if (CE) seen = 1;
    end
    chk("max_period", cyc, 256);
    chk("max_phase", maxph, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
